addsub_acc_stage: RTL and testbench
===================================

// Module: addsub_acc_stage
// PURPOSE
//   Registered operand/result stage wrapped around the external 8-bit add/sub datapath (SUBFA-style, ctrl=1 -> subtract).
//   Upstream half: accepts ops over valid/ready, selects operand A from the input or the accumulator, registers operands
//   and drives them to the adder. Downstream half: captures adder sum/carry, derives flags, optionally writes the
//   accumulator, and buffers results in a 2-entry output FIFO with valid/ready. Sits between the instruction/sequencer
//   logic and the result consumer.
// PARAMETERS
//   WIDTH      8   operand/result width; all data buses are [0:WIDTH-1], index 0 = MSB (sign bit)
// PORTS
//   clk        in   1      clock, all state on rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      op request valid
//   in_ready   out  1      stage accepts op this cycle when in_valid & in_ready
//   in_a       in   WIDTH  operand A (ignored when in_use_acc=1)
//   in_b       in   WIDTH  operand B
//   in_sub     in   1      1 = A-B, 0 = A+B
//   in_use_acc in   1      1 = operand A taken from accumulator
//   in_wr_acc  in   1      1 = result written to accumulator on capture
//   acc_clr    in   1      clear accumulator to 0
//   op_x       out  WIDTH  operand A to adder (registered)
//   op_y       out  WIDTH  operand B to adder (registered, uninverted)
//   op_sub     out  1      subtract control to adder (registered)
//   res_z      in   WIDTH  adder sum, combinational from op_x/op_y/op_sub
//   res_cout   in   1      adder carry out
//   out_valid  out  1      FIFO head valid
//   out_ready  in   1      consumer pops head when out_valid & out_ready
//   out_data   out  WIDTH  result
//   out_flags  out  4      {Z,N,C,V}
//   acc_q      out  WIDTH  accumulator value
// BEHAVIOUR
//   Reset: in_ready=1, out_valid=0, out_data=0, out_flags=0, op_x=op_y=0, op_sub=0, acc_q=0, FIFO count=0,
//     operand stage empty. Reset mid-operation discards in-flight op and all buffered results.
//   Operand stage (S1): one register set + valid bit. Loads on accept. Drives op_x/op_y/op_sub for whole residency.
//   Capture (S1->FIFO): occurs when S1 valid and (fifo_count<2 or pop this cycle). Writes {res_z, flags} to FIFO tail.
//   in_ready = !S1_valid | capture. Combinational from FIFO state and out_ready; no dependence on in_valid.
//   Latency: accept at edge N -> result at FIFO head (out_valid=1) after edge N+1 when FIFO was empty; 1 op/cycle sustained.
//   Flags at capture: Z = (res_z==0); N = res_z[0]; C = res_cout (subtract: 1 = no borrow);
//     V = add: (x[0]==y[0]) & (res_z[0]!=x[0]); sub: (x[0]!=y[0]) & (res_z[0]!=x[0]).
//   Accumulator: on capture with S1 wr_acc=1, acc_q <= res_z. acc_clr has priority over same-cycle write (acc_q <= 0).
//   Operand A select on accept with in_use_acc=1, priority order:
//     1) acc_clr this cycle -> 0;
//     2) S1 holds wr_acc op captured this cycle -> res_z (forwarded);
//     3) otherwise acc_q.
//   Hazard: accept with in_use_acc=1 while S1 holds uncaptured wr_acc op cannot occur (in_ready=0 in that case).
//   FIFO: 2 entries, head -> out_data/out_flags. Simultaneous push and pop at count=2 legal, count unchanged.
//     Pop when empty ignored. Pointers wrap modulo 2. out_data/out_flags hold last head value when empty.
//   Modular arithmetic: result truncated to WIDTH; wrap 0xFF+0x01 -> 0x00, C=1.
// TESTING
//   Add: A=0x3C, B=0x05, sub=0 -> out_data=0x41, flags Z0 N0 C0 V0, out_valid one cycle after accept.
//   Sub/overflow: A=0x80, B=0x01, sub=1 -> 0x7F, N0 C1 V1; A=0x05, B=0x05, sub=1 -> 0x00, Z1 C1.
//   Accumulate chain: acc_clr; then 4 back-to-back ops use_acc=1, wr_acc=1, B=0x40 add -> outputs 0x40,0x80,0xC0,0x00;
//     last op Z1 C1; acc_q=0x00; no bubbles.
//   Backpressure: out_ready=0, issue 4 ops -> 3 accepted (2 FIFO + S1), in_ready=0; release -> in-order results, none lost.
//   Reset mid-stream: rst with S1 and FIFO full -> next cycle out_valid=0, in_ready=1, acc_q=0.
//   Edge: simultaneous push/pop at count=2 and acc_clr coincident with wr_acc capture -> acc_q=0.

Source files
------------

// File: rtl/addsub_acc_stage.sv
// addsub_acc_stage
//   Registered operand/result stage around an external add/sub datapath
//   (ctrl=1 -> subtract). The upstream half accepts ops over valid/ready,
//   picks operand A from the input or the accumulator (with forwarding of a
//   same-cycle accumulator write), and holds the operands on op_x/op_y/op_sub
//   for the whole S1 residency. The downstream half captures the adder result,
//   derives {Z,N,C,V}, optionally updates the accumulator and buffers results
//   in a 2-entry FIFO.
//
// Ports
//   clk, rst                    clock / synchronous active-high reset
//   in_valid/in_ready           op request handshake
//   in_a, in_b, in_sub          operands and subtract select
//   in_use_acc, in_wr_acc       A from accumulator / write result to accumulator
//   acc_clr                     clear accumulator (wins over a same-cycle write)
//   op_x, op_y, op_sub          registered operands to the external adder
//   res_z, res_cout             external adder sum / carry (combinational)
//   out_valid/out_ready         result handshake (FIFO head)
//   out_data, out_flags         result and {Z,N,C,V}
//   acc_q                       accumulator value
//
// Buses are [0:WIDTH-1] with bit 0 as the MSB (sign bit).
module addsub_acc_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:WIDTH-1] in_a,
  input  logic [0:WIDTH-1] in_b,
  input  logic             in_sub,
  input  logic             in_use_acc,
  input  logic             in_wr_acc,
  input  logic             acc_clr,
  output logic [0:WIDTH-1] op_x,
  output logic [0:WIDTH-1] op_y,
  output logic             op_sub,
  input  logic [0:WIDTH-1] res_z,
  input  logic             res_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:WIDTH-1] out_data,
  output logic [3:0]       out_flags,
  output logic [0:WIDTH-1] acc_q
);

  typedef struct packed {
    logic [0:WIDTH-1] data;
    logic [3:0]       flags;
  } ent_t;

  // operand stage
  logic             r_s1_vld;
  logic             r_s1_wr_acc;
  logic [0:WIDTH-1] r_x;
  logic [0:WIDTH-1] r_y;
  logic             r_sub;
  logic [0:WIDTH-1] r_acc;

  // result FIFO
  ent_t             r_fifo [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_cnt;
  ent_t             r_last;      // last popped head, shown while empty

  logic             w_pop;
  logic             w_push;
  logic             w_accept;
  logic             w_fwd;
  logic             w_v;
  logic [3:0]       w_flags;
  logic [0:WIDTH-1] w_opa;
  ent_t             w_head;

  assign w_pop    = (r_cnt != 2'd0) & out_ready;
  // capture needs a free slot; a pop this cycle frees one at count=2
  assign w_push   = r_s1_vld & ((r_cnt != 2'd2) | w_pop);
  assign in_ready = ~r_s1_vld | w_push;
  assign w_accept = in_valid & in_ready;
  assign w_fwd    = w_push & r_s1_wr_acc;

  // A select: clear beats forwarding beats the stored accumulator. An
  // uncaptured wr_acc op in S1 forces in_ready=0, so acc_q is never stale here.
  always_comb begin
    w_opa = in_a;
    if (in_use_acc) begin
      if (acc_clr)    w_opa = '0;
      else if (w_fwd) w_opa = res_z;
      else            w_opa = r_acc;
    end
  end

  // overflow: add needs equal operand signs, sub needs differing signs,
  // and in both cases the result sign differs from x
  assign w_v     = ((r_x[0] ^ r_y[0]) == r_sub) & (res_z[0] ^ r_x[0]);
  assign w_flags = {(res_z == '0), res_z[0], res_cout, w_v};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld    <= 1'b0;
      r_s1_wr_acc <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
      r_sub       <= 1'b0;
      r_acc       <= '0;
      r_fifo[0]   <= '0;
      r_fifo[1]   <= '0;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_cnt       <= 2'd0;
      r_last      <= '0;
    end else begin
      if (w_accept) begin
        r_s1_vld    <= 1'b1;
        r_s1_wr_acc <= in_wr_acc;
        r_x         <= w_opa;
        r_y         <= in_b;
        r_sub       <= in_sub;
      end else if (w_push) begin
        r_s1_vld    <= 1'b0;
      end

      if (acc_clr)    r_acc <= '0;
      else if (w_fwd) r_acc <= res_z;

      // at count=2 push and pop hit the same slot; the read is of the old
      // value this cycle, the new entry becomes the tail after the edge
      if (w_push) begin
        r_fifo[r_wr_ptr] <= '{data: res_z, flags: w_flags};
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_last   <= r_fifo[r_rd_ptr];
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign w_head    = (r_cnt != 2'd0) ? r_fifo[r_rd_ptr] : r_last;
  assign out_valid = (r_cnt != 2'd0);
  assign out_data  = w_head.data;
  assign out_flags = w_head.flags;
  assign op_x      = r_x;
  assign op_y      = r_y;
  assign op_sub    = r_sub;
  assign acc_q     = r_acc;

endmodule

// File: tb/tb_addsub_acc_stage.sv
// Bench for addsub_acc_stage: external adder modelled as plain arithmetic,
// results checked against a program-order reference model (queue of expected
// results plus a software accumulator).
module tb_addsub_acc_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic [0:7] in_a, in_b;
  logic       in_sub, in_use_acc, in_wr_acc, acc_clr;
  logic [0:7] op_x, op_y;
  logic       op_sub;
  logic [0:7] res_z;
  logic       res_cout;
  logic       out_valid, out_ready;
  logic [0:7] out_data;
  logic [3:0] out_flags;
  logic [0:7] acc_q;
  logic [8:0] w_sum;

  always #5 clk = ~clk;

  // external add/sub datapath
  assign w_sum    = op_sub ? ({1'b0, op_x} + {1'b0, ~op_y} + 9'd1)
                           : ({1'b0, op_x} + {1'b0, op_y});
  assign res_z    = w_sum[7:0];
  assign res_cout = w_sum[8];

  addsub_acc_stage #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
    .in_use_acc(in_use_acc), .in_wr_acc(in_wr_acc), .acc_clr(acc_clr),
    .op_x(op_x), .op_y(op_y), .op_sub(op_sub),
    .res_z(res_z), .res_cout(res_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_flags(out_flags), .acc_q(acc_q)
  );

  typedef struct {
    logic [7:0] data;
    logic [3:0] flags;
  } exp_t;

  exp_t exp_q[$];
  int   m_acc;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int sx8(input int v);
    return (v > 127) ? v - 256 : v;
  endfunction

  // reference: each accepted op in program order
  function automatic void model_push(input logic [7:0] a, input logic [7:0] b,
                                     input bit sub, input bit ua, input bit wa, input bit clr);
    int x, y, r, sr, z;
    bit c, v;
    exp_t e;
    if (clr) m_acc = 0;
    x = ua ? m_acc : int'(a);
    y = int'(b);
    if (sub) begin
      r  = x - y;
      c  = (x >= y);
      sr = sx8(x) - sx8(y);
    end else begin
      r  = x + y;
      c  = (r > 255);
      sr = sx8(x) + sx8(y);
    end
    v = (sr > 127) || (sr < -128);
    z = r & 255;
    e.data  = z[7:0];
    e.flags = {z == 0, z > 127, c, v};
    exp_q.push_back(e);
    if (wa) m_acc = z;
  endfunction

  // one clock: drive at negedge, observe handshakes, advance to next negedge
  task automatic step(input bit v, input logic [7:0] a, input logic [7:0] b,
                      input bit sub, input bit ua, input bit wa, input bit clr,
                      input bit ordy, output bit acc);
    exp_t e;
    in_valid = v; in_a = a; in_b = b; in_sub = sub;
    in_use_acc = ua; in_wr_acc = wa; acc_clr = clr; out_ready = ordy;
    #1;
    // only clear when S1 is empty or capturing, so program order is well defined
    if (acc_clr && !in_ready) acc_clr = 1'b0;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("spurious_out", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("out_data", 32'(out_data), 32'(e.data));
        chk("out_flags", 32'(out_flags), 32'(e.flags));
      end
    end
    acc = in_valid && in_ready;
    if (acc) model_push(a, b, sub, ua, wa, acc_clr);
    else if (acc_clr) m_acc = 0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    bit acc;
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0; acc_clr = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    m_acc = 0;
  endtask

  task automatic directed(input logic [7:0] a, input logic [7:0] b, input bit sub,
                          input logic [7:0] ed, input logic [3:0] ef, input string tag);
    bit acc;
    step(1'b1, a, b, sub, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    chk({tag, "_acc"}, 32'(acc), 32'd1);
    chk({tag, "_opx"}, 32'(op_x), 32'(a));
    chk({tag, "_opy"}, 32'(op_y), 32'(b));
    chk({tag, "_opsub"}, 32'(op_sub), 32'(sub));
    chk({tag, "_vld0"}, 32'(out_valid), 32'd0);
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    chk({tag, "_vld1"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, 32'(out_data), 32'(ed));
    chk({tag, "_flags"}, 32'(out_flags), 32'(ef));
    drain();
  endtask

  initial begin
    bit acc;
    int nacc;
    bit v, sub, ua, wa, clr, ordy;
    logic [7:0] a, b;

    in_a = '0; in_b = '0; in_sub = 1'b0; in_use_acc = 1'b0; in_wr_acc = 1'b0;
    do_reset();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_flags", 32'(out_flags), 32'd0);
    chk("rst_op_x", 32'(op_x), 32'd0);
    chk("rst_op_y", 32'(op_y), 32'd0);
    chk("rst_op_sub", 32'(op_sub), 32'd0);
    chk("rst_acc_q", 32'(acc_q), 32'd0);

    // basic add / subtract with overflow / zero result ({Z,N,C,V})
    directed(8'h3C, 8'h05, 1'b0, 8'h41, 4'b0000, "add");
    directed(8'h80, 8'h01, 1'b1, 8'h7F, 4'b0011, "subov");
    directed(8'h05, 8'h05, 1'b1, 8'h00, 4'b1010, "subz");
    chk("hold_data", 32'(out_data), 32'h00);
    chk("hold_flags", 32'(out_flags), 32'b1010);

    // accumulate chain, back-to-back with forwarding
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, acc);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'hAA, 8'h40, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, acc);
      chk("chain_nobubble", 32'(acc), 32'd1);
    end
    drain();
    chk("chain_acc_q", 32'(acc_q), 32'h00);

    // backpressure: 3 of 4 accepted
    nacc = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'(8'h10 + i), 8'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, acc);
      nacc += int'(acc);
    end
    chk("bp_accepts", 32'(nacc), 32'd3);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    drain();

    // simultaneous push/pop at count=2 with acc_clr on a wr_acc capture
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h21 * (i + 1)), 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, acc);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, acc);
    chk("clr_vs_wr_acc_q", 32'(acc_q), 32'd0);
    step(1'b1, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, acc);
    chk("refill_acc", 32'(acc), 32'd1);
    step(1'b1, 8'h01, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    chk("pushpop_full_acc", 32'(acc), 32'd1);
    chk("pushpop_full_vld", 32'(out_valid), 32'd1);
    drain();
    chk("pp_acc_q", 32'(acc_q), 32'(m_acc));

    // reset with S1 and FIFO full
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h11 * (i + 1)), 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, acc);
    chk("pre_rst_acc_nz", 32'(acc_q != 8'h00), 32'd1);
    do_reset();
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_acc", 32'(acc_q), 32'd0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      v    = ($urandom_range(0, 3) != 0);
      a    = 8'($urandom);
      b    = 8'($urandom);
      sub  = 1'($urandom);
      ua   = 1'($urandom);
      wa   = 1'($urandom);
      clr  = ($urandom_range(0, 7) == 0);
      ordy = ($urandom_range(0, 2) != 0);
      step(v, a, b, sub, ua, wa, clr, ordy, acc);
    end
    drain();
    chk("rand_acc_q", 32'(acc_q), 32'(m_acc));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
